mips_dump_sequencer: RTL

MIPS_DUMP_SEQUENCER -- requirements
Module: mips_dump_sequencer

---
 rtl/mips_dump_sequencer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mips_dump_sequencer.sv
// MIPS dump sequencer: streams PC, register file and data memory
// to a UART TX FIFO, MSB first. Optional PC word: DUMP_PC_EN.
module mips_dump_sequencer #(
   parameter int NB_DATA   = 32,
   parameter int NB_BYTE   = 8,
   parameter int N_REGS    = 32,
   parameter int MEM_WORDS = 128
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic               i_abort,
   input  logic               i_tx_full,
   input  logic [NB_DATA-1:0] i_reg_data,
   input  logic [NB_DATA-1:0] i_mem_data,
   input  logic [NB_DATA-1:0] i_pc,
   output logic               o_wr_uart,
   output logic [NB_BYTE-1:0] o_tx_data,
   output logic [4:0]         o_reg_addr,
   output logic [NB_DATA-1:0] o_mem_addr,
   output logic               o_busy,
   output logic               o_done
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PC,
      ST_REG,
      ST_MEM,
      ST_DONE
   } state_t;

   localparam logic [4:0] LP_REG_LAST =
      5'(N_REGS - 1);
   localparam logic [NB_DATA-1:0] LP_MEM_LAST =
      NB_DATA'(4 * (MEM_WORDS - 1));
   localparam logic [NB_DATA-1:0] LP_MEM_STEP =
      NB_DATA'(4);

   state_t             r_state;
   logic [1:0]         r_byte_cnt;
   logic [4:0]         r_reg_addr;
   logic [NB_DATA-1:0] r_mem_addr;

   state_t             w_next_state;
   logic [1:0]         w_next_cnt;
   logic [4:0]         w_next_reg;
   logic [NB_DATA-1:0] w_next_mem;
   logic               w_wr;
   logic               w_done;
   logic               w_last_byte;
   logic [NB_DATA-1:0] w_word;
   logic [NB_BYTE-1:0] w_byte;

`ifndef DUMP_PC_EN
   logic               w_unused_pc;
   assign w_unused_pc = ^i_pc;
`endif

   assign w_last_byte = (r_byte_cnt == 2'd3);

   // State, byte counter and address registers
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state    <= ST_IDLE;
         r_byte_cnt <= 2'd0;
         r_reg_addr <= 5'd0;
         r_mem_addr <= '0;
      end else begin
         r_state    <= w_next_state;
         r_byte_cnt <= w_next_cnt;
         r_reg_addr <= w_next_reg;
         r_mem_addr <= w_next_mem;
      end
   end

   // Next-state, sequencing and strobe logic
   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_byte_cnt;
      w_next_reg   = r_reg_addr;
      w_next_mem   = r_mem_addr;
      w_wr         = 1'b0;
      w_done       = 1'b0;
      if (i_abort) begin
         w_next_state = ST_IDLE;
         w_next_cnt   = 2'd0;
         w_next_reg   = 5'd0;
         w_next_mem   = '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               w_next_cnt = 2'd0;
               if (i_start) begin
`ifdef DUMP_PC_EN
                  w_next_state = ST_PC;
`else
                  w_next_state = ST_REG;
`endif
               end
            end
            ST_PC: begin
               if (!i_tx_full) begin
                  w_wr       = 1'b1;
                  w_next_cnt = r_byte_cnt + 2'd1;
                  if (w_last_byte) begin
                     w_next_state = ST_REG;
                  end
               end
            end
            ST_REG: begin
               if (!i_tx_full) begin
                  w_wr       = 1'b1;
                  w_next_cnt = r_byte_cnt + 2'd1;
                  if (w_last_byte) begin
                     if (r_reg_addr == LP_REG_LAST) begin
                        w_next_state = ST_MEM;
                     end else begin
                        w_next_reg = r_reg_addr + 5'd1;
                     end
                  end
               end
            end
            ST_MEM: begin
               if (!i_tx_full) begin
                  w_wr       = 1'b1;
                  w_next_cnt = r_byte_cnt + 2'd1;
                  if (w_last_byte) begin
                     if (r_mem_addr == LP_MEM_LAST) begin
                        w_next_state = ST_DONE;
                     end else begin
                        w_next_mem = r_mem_addr + LP_MEM_STEP;
                     end
                  end
               end
            end
            ST_DONE: begin
               w_done       = 1'b1;
               w_next_state = ST_IDLE;
               w_next_cnt   = 2'd0;
               w_next_reg   = 5'd0;
               w_next_mem   = '0;
            end
            default: begin
               w_next_state = ST_IDLE;
               w_next_cnt   = 2'd0;
               w_next_reg   = 5'd0;
               w_next_mem   = '0;
            end
         endcase
      end
   end

   // Word source for the current state; zero when nothing is sent
   always_comb begin
      w_word = '0;
      unique case (r_state)
`ifdef DUMP_PC_EN
         ST_PC:   w_word = i_pc;
`endif
         ST_REG:  w_word = i_reg_data;
         ST_MEM:  w_word = i_mem_data;
         default: w_word = '0;
      endcase
   end

   // Byte lane select, MSB first
   always_comb begin
      w_byte = '0;
      unique case (r_byte_cnt)
         2'd0: w_byte = w_word[NB_DATA-1 -: NB_BYTE];
         2'd1: w_byte = w_word[NB_DATA-1-NB_BYTE -: NB_BYTE];
         2'd2: w_byte = w_word[NB_DATA-1-2*NB_BYTE -: NB_BYTE];
         2'd3: w_byte = w_word[NB_DATA-1-3*NB_BYTE -: NB_BYTE];
         default: w_byte = '0;
      endcase
   end

   assign o_wr_uart  = w_wr;
   assign o_tx_data  = w_byte;
   assign o_reg_addr = r_reg_addr;
   assign o_mem_addr = r_mem_addr;
   assign o_busy     = (r_state != ST_IDLE);
   assign o_done     = w_done;

endmodule
